// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and helpers for mem_port_arbiter
//
// Contents:
//   arb_state_t : access sequencer states (IDLE, SETUP, ACCESS, RESP)
//   CNT_W       : width of the ACCESS wait counter (covers WAIT_CYCLES up to 7)
//   clog2()     : index width for a requester count

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int CNT_W = 3;

  // Smallest r with 2**r >= n; a single requester still gets a 0-bit-free
  // answer of 0, callers only use it for n >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req   in  NUM_REQ  raw request vector
//   ptr   in  IDX_W    index with top priority this cycle
//   mask  in  NUM_REQ  requesters excluded from this pick
//   valid out 1        at least one eligible requester
//   grant out NUM_REQ  one-hot winner
//   idx   out IDX_W    binary winner index

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  localparam int SUM_W = IDX_W + 1;

  logic [NUM_REQ-1:0] elig;

  assign elig = req & ~mask;

  // Walk the requesters starting at ptr and wrapping; the first eligible
  // one wins. The sum is one bit wider than the index so ptr+i never
  // overflows before the modulo subtraction.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] c;
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    sum   = '0;
    c     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      c = sum[IDX_W-1:0];
      if (!valid && elig[c]) begin
        valid    = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter and access sequencer for one single-port memory
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req         in  NUM_REQ          per-requester request, held until ack
//   we          in  NUM_REQ          per-requester write select
//   addr        in  NUM_REQ*ADDR_W   packed word addresses
//   wdata       in  NUM_REQ*DATA_W   packed write data
//   ack         out NUM_REQ          one-hot one-cycle completion pulse
//   rdata       out DATA_W           read data, valid in the ack cycle
//   busy        out 1                sequencer not idle
//   mem_en      out 1                memory enable
//   mem_we      out 1                memory write strobe
//   mem_addr    out ADDR_W           memory word address
//   mem_wdata   out DATA_W           memory write data
//   mem_rdata   in  DATA_W           memory read data, one cycle after mem_en

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 24,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int               IDX_W    = clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t state, state_nxt;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_next;
  logic [IDX_W-1:0]   win;
  logic [NUM_REQ-1:0] win_oh;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [CNT_W-1:0]   cnt;

  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               load;

  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  assign ptr_next = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  assign win_oh   = NUM_REQ'(1) << win;

  // In RESP the pick already sees the advanced pointer and the current
  // winner masked out, so a back-to-back grant never repeats the requester
  // that was just served.
  assign pick_ptr  = (state == RESP) ? ptr_next : ptr;
  assign pick_mask = (state == RESP) ? win_oh : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .valid (pick_valid),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Steer the winning requester's fields with the one-hot grant.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // A new transaction is captured on the edge that enters SETUP, so the
  // SETUP cycle already drives the latched address/data and nothing the
  // requester does afterwards can disturb the access in flight.
  assign load = pick_valid && ((state == IDLE) || (state == RESP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    ack       = '0;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = SETUP;
      end
      SETUP: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        busy   = 1'b1;
        mem_en = 1'b1;
        mem_we = lat_we;
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        ack       = win_oh;
        state_nxt = pick_valid ? SETUP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      win       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rdata     <= '0;
    end else begin
      if (load) begin
        win       <= pick_idx;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end
      if (state == SETUP) begin
        cnt <= CNT_LOAD;
      end else if ((state == ACCESS) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      // Memory data is registered one cycle behind mem_en, which first rises
      // in SETUP, so it is valid throughout ACCESS.
      if ((state == ACCESS) && (cnt == '0) && !lat_we) begin
        rdata <= mem_rdata;
      end
      if (state == RESP) begin
        ptr <= ptr_next;
      end
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [N-1:0]    req, we, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic            busy, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;

  logic [N-1:0]    req_b, we_b, ack_b;
  logic [N*AW-1:0] addr_b;
  logic [N*DW-1:0] wdata_b;
  logic [DW-1:0]   rdata_b, mem_wdata_b, mem_rdata_b;
  logic            busy_b, mem_en_b, mem_we_b;
  logic [AW-1:0]   mem_addr_b;

  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_a[9] <= 24'h123456;
    end else if (mem_en) begin
      if (mem_we) mem_a[mem_addr] <= mem_wdata;
      mem_rdata <= mem_a[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (rst_n && mem_en_b) begin
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
      mem_rdata_b <= mem_b[mem_addr_b];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i]             = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
    req[i]            = 1'b1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    rst_n = 1'b0;
    tick;
    checks++;
    if (ack !== 4'b0) begin failures++; $display("FAIL reset_ack got=%b exp=%b", ack, 4'b0); end
    checks++;
    if ({busy, mem_en, mem_we} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", {busy, mem_en, mem_we}, 3'b000); end
    checks++;
    if ({mem_addr, mem_wdata, rdata} !== 53'd0) begin failures++; $display("FAIL reset_data got=%h exp=%h", {mem_addr, mem_wdata, rdata}, 53'd0); end
    checks++;
    if ({busy_b, ack_b, rdata_b} !== 29'd0) begin failures++; $display("FAIL reset_dut3 got=%h exp=%h", {busy_b, ack_b, rdata_b}, 29'd0); end
    rst_n = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%b exp=%b", busy, 1'b0); end
  endtask

  task automatic test_single_read;
    int wcnt;
    wcnt = 0;
    set_req(1, 1'b0, 5'd9, 24'h0);
    tick;
    wcnt += int'(mem_we);
    checks++;
    if ({busy, mem_en, mem_we} !== 3'b110) begin failures++; $display("FAIL rd_setup_ctrl got=%b exp=%b", {busy, mem_en, mem_we}, 3'b110); end
    checks++;
    if (mem_addr !== 5'd9) begin failures++; $display("FAIL rd_setup_addr got=%0d exp=%0d", mem_addr, 9); end
    tick;
    wcnt += int'(mem_we);
    tick;
    wcnt += int'(mem_we);
    checks++;
    if (ack !== 4'b0010) begin failures++; $display("FAIL rd_ack got=%b exp=%b", ack, 4'b0010); end
    checks++;
    if (rdata !== 24'h123456) begin failures++; $display("FAIL rd_data got=%h exp=%h", rdata, 24'h123456); end
    req[1] = 1'b0;
    tick;
    checks++;
    if ({busy, ack} !== 5'b0) begin failures++; $display("FAIL rd_after got=%b exp=%b", {busy, ack}, 5'b0); end
    checks++;
    if (wcnt !== 0) begin failures++; $display("FAIL rd_no_we got=%0d exp=%0d", wcnt, 0); end
  endtask

  task automatic test_single_write;
    int wcnt;
    wcnt = 0;
    set_req(2, 1'b1, 5'd9, 24'hA5A5A5);
    tick;
    wcnt += int'(mem_we);
    checks++;
    if ({busy, mem_en, mem_we} !== 3'b110) begin failures++; $display("FAIL wr_setup_ctrl got=%b exp=%b", {busy, mem_en, mem_we}, 3'b110); end
    tick;
    wcnt += int'(mem_we);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 5'd9, 24'hA5A5A5}) begin
      failures++;
      $display("FAIL wr_access got=%h exp=%h", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 5'd9, 24'hA5A5A5});
    end
    tick;
    wcnt += int'(mem_we);
    checks++;
    if ({ack, busy, mem_we} !== 6'b0100_10) begin failures++; $display("FAIL wr_resp got=%b exp=%b", {ack, busy, mem_we}, 6'b0100_10); end
    checks++;
    if (rdata !== 24'h123456) begin failures++; $display("FAIL wr_rdata_held got=%h exp=%h", rdata, 24'h123456); end
    req[2] = 1'b0;
    we[2]  = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL wr_after_busy got=%b exp=%b", busy, 1'b0); end
    checks++;
    if (wcnt !== 1) begin failures++; $display("FAIL wr_we_cycles got=%0d exp=%0d", wcnt, 1); end
  endtask

  task automatic test_readback;
    set_req(1, 1'b0, 5'd9, 24'h0);
    tick;
    tick;
    tick;
    checks++;
    if ({ack, rdata} !== {4'b0010, 24'hA5A5A5}) begin failures++; $display("FAIL readback got=%h exp=%h", {ack, rdata}, {4'b0010, 24'hA5A5A5}); end
    req = '0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] exp_ack [4];
    int k;
    int gap;
    exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100; exp_ack[3] = 4'b1000;
    k = 0;
    gap = 0;
    do_reset;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 24'h0);
    for (int t = 1; t <= 16; t++) begin
      tick;
      if (t <= 12 && busy !== 1'b1) gap++;
      if (ack !== 4'b0) begin
        checks++;
        if (k < 4 && (ack !== exp_ack[k] || t !== 3 * (k + 1))) begin
          failures++;
          $display("FAIL b2b_ack%0d got=%b@%0d exp=%b@%0d", k, ack, t, exp_ack[k], 3 * (k + 1));
        end else if (k >= 4) begin
          failures++;
          $display("FAIL b2b_extra_ack got=%b exp=none", ack);
        end
        req = req & ~ack;
        k++;
      end
    end
    checks++;
    if (k !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", k, 4); end
    checks++;
    if (gap !== 0) begin failures++; $display("FAIL b2b_idle_gap got=%0d exp=%0d", gap, 0); end
  endtask

  task automatic test_fairness;
    logic [N-1:0] exp_ack [3];
    int exp_t [3];
    int n;
    exp_ack[0] = 4'b0001; exp_ack[1] = 4'b1000; exp_ack[2] = 4'b0001;
    exp_t[0] = 3; exp_t[1] = 6; exp_t[2] = 9;
    n = 0;
    do_reset;
    set_req(0, 1'b0, 5'd1, 24'h0);
    for (int t = 1; t <= 16; t++) begin
      tick;
      if (ack !== 4'b0) begin
        checks++;
        if (n >= 3 || ack !== exp_ack[n] || t !== exp_t[n]) begin
          failures++;
          $display("FAIL fair_ack%0d got=%b@%0d exp=%b@%0d", n, ack, t, exp_ack[n % 3], exp_t[n % 3]);
        end
        if (ack[3]) req[3] = 1'b0;
        n++;
        if (n == 3) req[0] = 1'b0;
      end
      if (t == 1) set_req(3, 1'b0, 5'd2, 24'h0);
    end
    checks++;
    if (n !== 3) begin failures++; $display("FAIL fair_count got=%0d exp=%0d", n, 3); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    set_req(1, 1'b0, 5'd3, 24'h0);
    tick;
    tick;
    tick;
    checks++;
    if (ack !== 4'b0010) begin failures++; $display("FAIL rm_pre_ack got=%b exp=%b", ack, 4'b0010); end
    req = '0;
    tick;
    set_req(2, 1'b1, 5'd7, 24'h0BAD01);
    tick;
    tick;
    checks++;
    if ({mem_en, mem_we} !== 2'b11) begin failures++; $display("FAIL rm_in_access got=%b exp=%b", {mem_en, mem_we}, 2'b11); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, busy, ack} !== 7'b0) begin failures++; $display("FAIL rm_drop got=%b exp=%b", {mem_en, mem_we, busy, ack}, 7'b0); end
    set_req(0, 1'b0, 5'd4, 24'h0);
    set_req(2, 1'b0, 5'd5, 24'h0);
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    tick;
    checks++;
    if (ack !== 4'b0001) begin failures++; $display("FAIL rm_first_after got=%b exp=%b", ack, 4'b0001); end
    req[0] = 1'b0;
    tick;
    tick;
    tick;
    checks++;
    if (ack !== 4'b0100) begin failures++; $display("FAIL rm_second_after got=%b exp=%b", ack, 4'b0100); end
    req = '0;
    tick;
  endtask

  task automatic test_wait3;
    int wcnt;
    int first;
    wcnt = 0;
    first = 0;
    we_b[0]          = 1'b1;
    addr_b[0 +: AW]  = 5'd4;
    wdata_b[0 +: DW] = 24'h00C0DE;
    req_b[0]         = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick;
      wcnt += int'(mem_we_b);
      if (ack_b !== 4'b0 && first == 0) begin
        first = t;
        checks++;
        if (ack_b !== 4'b0001) begin failures++; $display("FAIL w3_ack got=%b exp=%b", ack_b, 4'b0001); end
        req_b = '0;
        we_b  = '0;
      end
    end
    checks++;
    if (first !== 5) begin failures++; $display("FAIL w3_latency got=%0d exp=%0d", first, 5); end
    checks++;
    if (wcnt !== 3) begin failures++; $display("FAIL w3_we_cycles got=%0d exp=%0d", wcnt, 3); end
    checks++;
    if (mem_b[4] !== 24'h00C0DE) begin failures++; $display("FAIL w3_mem got=%h exp=%h", mem_b[4], 24'h00C0DE); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_single_write;
    test_readback;
    test_back_to_back;
    test_fairness;
    test_reset_mid;
    test_wait3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
